// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode encoding and default width.
package usr_pkg;

    // Default register width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Mode encoding, indexed as {shift_left, shift_right}.
    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Signal bundle for the universal shift register's control/data side.
// There is no handshake: every field is sampled on each rising clk edge.
// The master drives the controls and load data; the slave returns the register.
interface universal_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             shift_left;
    logic             shift_right;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;

    modport master (
        output shift_left,
        output shift_right,
        output parallel_in,
        input  parallel_out
    );

    modport slave (
        input  shift_left,
        input  shift_right,
        input  parallel_in,
        output parallel_out
    );
endinterface

// File: rtl/usr_next_value.sv
// Combinational next-state mux: load, zero-fill shift left/right, or hold.
module usr_next_value
    import usr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] next_q
);

    // Select the next register value; conflicting shift requests hold.
    always_comb begin
        next_q = q;
        case (mode)
            MODE_LOAD: next_q = parallel_in;
            MODE_SHL:  next_q = {q[WIDTH-2:0], 1'b0};
            MODE_SHR:  next_q = {1'b0, q[WIDTH-1:1]};
            MODE_HOLD: next_q = q;
            default:   next_q = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, logical shift left/right, hold.
// Ports stay flat and in fixed order so positional instantiation works.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_left,
    input  logic             shift_right,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out
);

    mode_e            mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] next_q;

    assign mode = mode_e'({shift_left, shift_right});

    usr_next_value #(
        .WIDTH (WIDTH)
    ) u_next_value (
        .mode        (mode),
        .q           (q),
        .parallel_in (parallel_in),
        .next_q      (next_q)
    );

    // Register with asynchronous active-low clear; otherwise takes the mux result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= next_q;
        end
    end

    assign parallel_out = q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg at WIDTH 8 and 16.
module tb_universal_shift_reg;

    logic clk;
    logic reset;

    universal_shift_reg_if #(.WIDTH(8))  bus8  ();
    universal_shift_reg_if #(.WIDTH(16)) bus16 ();

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .shift_left   (bus8.shift_left),
        .shift_right  (bus8.shift_right),
        .parallel_in  (bus8.parallel_in),
        .parallel_out (bus8.parallel_out)
    );

    universal_shift_reg #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .shift_left   (bus16.shift_left),
        .shift_right  (bus16.shift_right),
        .parallel_in  (bus16.parallel_in),
        .parallel_out (bus16.parallel_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controls must be known whenever the register is out of reset.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            assert (!$isunknown({bus8.shift_left, bus8.shift_right,
                                 bus16.shift_left, bus16.shift_right}))
                else $error("controls unknown while out of reset");
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [7:0]  model8;
    logic [15:0] model16;
    int          n_checks;
    int          n_pass;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [15:0] got);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, got);
        end else begin
            exp = exp_q.pop_front();
            check_val(tag, got, exp);
        end
    endtask

    // Independent reference of one clocked operation.
    function automatic logic [15:0] ref_next(input logic sl, input logic sr,
                                             input logic [15:0] cur, input logic [15:0] pin,
                                             input int w);
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        if (!sl && !sr)     return pin & mask;
        else if (sl && !sr) return (cur << 1) & mask;
        else if (!sl && sr) return (cur & mask) >> 1;
        else                return cur & mask;
    endfunction

    // ---------------- drivers ----------------
    task automatic op8(input logic sl, input logic sr, input logic [7:0] pin, input string tag);
        @(negedge clk);
        bus8.shift_left  = sl;
        bus8.shift_right = sr;
        bus8.parallel_in = pin;
        model8 = 8'(ref_next(sl, sr, {8'h00, model8}, {8'h00, pin}, 8));
        exp_q.push_back({8'h00, model8});
        @(posedge clk);
        #1;
        pop_check(tag, {8'h00, bus8.parallel_out});
    endtask

    task automatic op16(input logic sl, input logic sr, input logic [15:0] pin, input string tag);
        @(negedge clk);
        bus16.shift_left  = sl;
        bus16.shift_right = sr;
        bus16.parallel_in = pin;
        model16 = ref_next(sl, sr, model16, pin, 16);
        exp_q.push_back(model16);
        @(posedge clk);
        #1;
        pop_check(tag, bus16.parallel_out);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] shl_seq_sl;
        logic [7:0] shl_seq_sr;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        bus8.shift_left   = 1'b0;
        bus8.shift_right  = 1'b0;
        bus8.parallel_in  = 8'hE5;
        bus16.shift_left  = 1'b1;
        bus16.shift_right = 1'b1;
        bus16.parallel_in = 16'h0000;
        model8  = 8'h00;
        model16 = 16'h0000;

        // Reset clears with no clock edge.
        #2;
        check_val("reset_async", {8'h00, bus8.parallel_out}, 16'h0000);
        check_val("reset_async16", bus16.parallel_out, 16'h0000);
        @(posedge clk);
        #1;
        check_val("reset_held", {8'h00, bus8.parallel_out}, 16'h0000);
        #1;
        reset = 1'b1;

        // First edge after release loads.
        op8(1'b0, 1'b0, 8'hE5, "release_load");

        // Shift sequence SHL SHR SHL SHL SHR from E5.
        shl_seq_sl = 8'b0000_1101;
        shl_seq_sr = 8'b0001_0010;
        for (int i = 0; i < 5; i++) begin
            op8(shl_seq_sl[i], shl_seq_sr[i], 8'hE5, "shift_seq");
        end
        check_val("shift_seq_final", {8'h00, bus8.parallel_out}, 16'h004A);

        // Zero fill left and right.
        op8(1'b0, 1'b0, 8'hFF, "load_ff");
        for (int i = 0; i < 8; i++) op8(1'b1, 1'b0, 8'(($urandom_range(0, 255))), "shl_fill");
        check_val("shl_fill_zero", {8'h00, bus8.parallel_out}, 16'h0000);
        op8(1'b0, 1'b0, 8'hFF, "load_ff");
        for (int i = 0; i < 8; i++) op8(1'b0, 1'b1, 8'(($urandom_range(0, 255))), "shr_fill");
        check_val("shr_fill_zero", {8'h00, bus8.parallel_out}, 16'h0000);

        // Conflicting requests hold while parallel_in toggles.
        op8(1'b0, 1'b0, 8'hA5, "load_a5");
        op8(1'b1, 1'b1, 8'h5A, "hold");
        op8(1'b1, 1'b1, 8'hFF, "hold");
        op8(1'b1, 1'b1, 8'h00, "hold");
        check_val("hold_final", {8'h00, bus8.parallel_out}, 16'h00A5);

        // Async reset in the middle of a shift run.
        op8(1'b0, 1'b0, 8'h65, "load_65");
        op8(1'b1, 1'b0, 8'h00, "shl_to_ca");
        reset = 1'b0;
        #1;
        check_val("reset_mid", {8'h00, bus8.parallel_out}, 16'h0000);
        #1;
        reset  = 1'b1;
        model8 = 8'h00;
        op8(1'b0, 1'b0, 8'h3C, "reload_after_reset");

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            op8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), "rand8");
        end

        // Width 16 boundaries.
        op16(1'b0, 1'b0, 16'h8001, "load_8001");
        op16(1'b1, 1'b0, 16'h1234, "shl16");
        check_val("shl16_value", bus16.parallel_out, 16'h0002);
        op16(1'b0, 1'b0, 16'h8001, "load_8001");
        op16(1'b0, 1'b1, 16'h1234, "shr16");
        check_val("shr16_value", bus16.parallel_out, 16'h4000);
        for (int i = 0; i < 16; i++) begin
            op16(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 65535)), "rand16");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
